// File: rtl/mrav_pkg.sv
// Shared mrav definitions: default bus widths, arbiter state/op encodings and
// small helpers used by the arbiter and its bus interface.
package mrav_pkg;

  localparam int MRAV_ADDR_WIDTH = 16;
  localparam int MRAV_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mrav_bus_arbiter_if.sv
// mrav bus master-side signal bundle; the arbiter drives it through the
// master modport, the bus fabric (or a bench) sits on the slave side.
interface mrav_bus_arbiter_if #(
  parameter int ADDR_WIDTH = mrav_pkg::MRAV_ADDR_WIDTH,
  parameter int DATA_WIDTH = mrav_pkg::MRAV_DATA_WIDTH
);

  logic                  bus_read;
  logic                  bus_write;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_data_out;
  logic [DATA_WIDTH-1:0] bus_data_in;
  logic                  bus_read_done;
  logic                  bus_write_done;

  modport master (
    output bus_read, bus_write, bus_addr, bus_data_out,
    input  bus_data_in, bus_read_done, bus_write_done
  );

  modport slave (
    input  bus_read, bus_write, bus_addr, bus_data_out,
    output bus_data_in, bus_read_done, bus_write_done
  );

endinterface

// File: rtl/mrav_rr_picker.sv
// Two-way round-robin picker: a lone pending requester wins, on a tie the
// requester that was not granted last wins. Purely combinational.
module mrav_rr_picker (
  input  logic [1:0] pending_i,
  input  logic       last_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = 2'b00;
    unique case (pending_i)
      2'b01:   winner_o = 2'b01;
      2'b10:   winner_o = 2'b10;
      2'b11:   winner_o = last_i ? 2'b01 : 2'b10;
      default: winner_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mrav_bus_arbiter.sv
// Two-master arbiter in front of the mrav bus: latches one request at a time,
// holds the bus strobe until the matching done or a wait-counter timeout.
module mrav_bus_arbiter
  import mrav_pkg::*;
#(
  parameter int ADDR_WIDTH     = MRAV_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MRAV_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_read,
  input  logic [1:0]                 req_write,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][DATA_WIDTH-1:0] req_data_out,
  output logic [DATA_WIDTH-1:0]      req_data_in,
  output logic [1:0]                 req_read_done,
  output logic [1:0]                 req_write_done,
  output logic [1:0]                 grant,
  output logic                       timeout_err,
  mrav_bus_arbiter_if.master         bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_e            state_q, state_d;
  arb_op_e               op_q, op_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [1:0] pending;
  logic [1:0] win_oh;
  logic       win_idx;
  logic       active;
  logic       match_done;
  logic       timeout_reached;

  assign pending = req_read | req_write;
  assign win_idx = win_oh[1];

  mrav_rr_picker u_picker (
    .pending_i (pending),
    .last_i    (last_q),
    .winner_o  (win_oh)
  );

  // Reset is gated in so a done arriving together with rst is never reported.
  assign active          = (state_q == BUSY) && !rst;
  assign match_done      = (op_q == OP_WRITE) ? bus.bus_write_done : bus.bus_read_done;
  assign timeout_reached = TIMEOUT_EN && (state_q == BUSY) && (cnt_q == TO_CNT);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|win_oh) begin
          state_d = BUSY;
          owner_d = win_idx;
          last_d  = win_idx;
          op_d    = req_write[win_idx] ? OP_WRITE : OP_READ;
          addr_d  = req_addr[win_idx];
          wdata_d = req_data_out[win_idx];
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (match_done || timeout_reached) begin
          state_d = IDLE;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.bus_read     = active && (op_q == OP_READ)  && !timeout_reached;
    bus.bus_write    = active && (op_q == OP_WRITE) && !timeout_reached;
    bus.bus_addr     = addr_q;
    bus.bus_data_out = wdata_q;
    grant            = active ? idx_to_onehot(owner_q) : 2'b00;
    req_read_done    = 2'b00;
    req_write_done   = 2'b00;
    req_data_in      = '0;
    timeout_err      = 1'b0;
    if (active) begin
      // A matching done in the timeout cycle still completes normally.
      if (match_done) begin
        if (op_q == OP_WRITE) begin
          req_write_done[owner_q] = 1'b1;
        end else begin
          req_read_done[owner_q] = 1'b1;
          req_data_in            = bus.bus_data_in;
        end
      end else if (timeout_reached) begin
        timeout_err = 1'b1;
        req_data_in = '1;
        if (op_q == OP_WRITE) begin
          req_write_done[owner_q] = 1'b1;
        end else begin
          req_read_done[owner_q] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mrav_bus_arbiter.sv
// Self-checking bench for mrav_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mrav_bus_arbiter;
  import mrav_pkg::*;

  localparam int AW = MRAV_ADDR_WIDTH;
  localparam int DW = MRAV_DATA_WIDTH;
  localparam int TO = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_read, req_write;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][DW-1:0]  req_data_out;
  logic [DW-1:0]       req_data_in;
  logic [1:0]          req_read_done, req_write_done, grant;
  logic                timeout_err;

  mrav_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mrav_bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_data_out   (req_data_out),
    .req_data_in    (req_data_in),
    .req_read_done  (req_read_done),
    .req_write_done (req_write_done),
    .grant          (grant),
    .timeout_err    (timeout_err),
    .bus            (bus_if)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus applied on the next cycle.
  logic               d_rst, d_brd, d_bwd;
  logic [1:0]         d_rd, d_wr;
  logic [1:0][AW-1:0] d_addr;
  logic [1:0][DW-1:0] d_dout;
  logic [DW-1:0]      d_bdin;

  // Transaction-level reference: one outstanding transfer and its age.
  bit          m_busy  = 1'b0;
  int          m_owner = 0;
  bit          m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int          m_age   = 0;
  int          m_last  = 1;

  // Snapshot of DUT outputs from the latest cycle, for directed checks.
  logic [1:0]    obs_grant, obs_rdone, obs_wdone;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_din;
  logic          obs_rs, obs_ws;
  int            terr_seen = 0;

  task automatic idle_in();
    d_rst = 1'b0; d_rd = 2'b00; d_wr = 2'b00; d_brd = 1'b0; d_bwd = 1'b0;
    d_bdin = '0;
  endtask

  task automatic cycle();
    bit            timed_out, hit;
    logic [1:0]    e_grant, e_rdone, e_wdone;
    logic [DW-1:0] e_din;
    logic          e_rs, e_ws, e_terr;
    int            pend;
    @(negedge clk);
    rst = d_rst; req_read = d_rd; req_write = d_wr;
    req_addr = d_addr; req_data_out = d_dout;
    bus_if.bus_read_done = d_brd; bus_if.bus_write_done = d_bwd;
    bus_if.bus_data_in = d_bdin;
    #1;
    obs_grant = grant; obs_rdone = req_read_done; obs_wdone = req_write_done;
    obs_addr = bus_if.bus_addr; obs_din = req_data_in;
    obs_rs = bus_if.bus_read; obs_ws = bus_if.bus_write;
    if (timeout_err === 1'b1) terr_seen++;

    timed_out = m_busy && (m_age >= TO);
    hit       = m_busy && (m_write ? d_bwd : d_brd);
    e_rs      = m_busy && !m_write && !timed_out;
    e_ws      = m_busy &&  m_write && !timed_out;
    e_grant   = !m_busy ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
    e_rdone = 2'b00; e_wdone = 2'b00; e_din = '0; e_terr = 1'b0;
    if (hit || timed_out) begin
      if (m_write) e_wdone[m_owner] = 1'b1;
      else         e_rdone[m_owner] = 1'b1;
      if (hit) e_din = m_write ? '0 : d_bdin;
      else begin e_din = '1; e_terr = 1'b1; end
    end

    if (d_rst) begin
      check("rdone_in_rst", 32'(req_read_done), 32'(2'b00));
      check("wdone_in_rst", 32'(req_write_done), 32'(2'b00));
      check("terr_in_rst", 32'(timeout_err), 32'(1'b0));
    end else begin
      check("bus_read", 32'(bus_if.bus_read), 32'(e_rs));
      check("bus_write", 32'(bus_if.bus_write), 32'(e_ws));
      check("grant", 32'(grant), 32'(e_grant));
      if (m_busy) begin
        check("bus_addr", 32'(bus_if.bus_addr), 32'(m_addr));
        if (m_write) check("bus_data_out", 32'(bus_if.bus_data_out), 32'(m_data));
      end
      check("read_done", 32'(req_read_done), 32'(e_rdone));
      check("write_done", 32'(req_write_done), 32'(e_wdone));
      check("data_in", 32'(req_data_in), 32'(e_din));
      check("timeout_err", 32'(timeout_err), 32'(e_terr));
    end

    @(posedge clk);
    if (d_rst) begin
      m_busy = 1'b0; m_last = 1; m_addr = '0; m_data = '0; m_age = 0;
    end else if (m_busy) begin
      if (hit || timed_out) m_busy = 1'b0;
      else m_age++;
    end else begin
      pend = int'(d_rd | d_wr);
      if (pend != 0) begin
        if (pend == 3) m_owner = 1 - m_last;
        else           m_owner = (pend == 2) ? 1 : 0;
        m_last  = m_owner;
        m_busy  = 1'b1;
        m_write = d_wr[m_owner];
        m_addr  = d_addr[m_owner];
        m_data  = d_dout[m_owner];
        m_age   = 0;
      end
    end
  endtask

  logic [1:0] rr_seen [3];

  initial begin
    d_addr = '0; d_dout = '0;
    idle_in();
    d_rst = 1'b1;
    cycle(); cycle();
    d_rst = 1'b0;
    cycle();
    check("rst_grant", 32'(obs_grant), 32'(2'b00));
    check("rst_strobes", 32'({obs_rs, obs_ws}), 32'(2'b00));
    check("rst_addr", 32'(obs_addr), 32'(0));

    // Reset forgets history, then contention must alternate core-first.
    d_rst = 1'b1; cycle(); d_rst = 1'b0;
    d_rd = 2'b11; d_brd = 1'b1; d_bdin = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i % 2 == 1) rr_seen[i / 2] = obs_grant;
    end
    check("rr_first", 32'(rr_seen[0]), 32'(2'b01));
    check("rr_second", 32'(rr_seen[1]), 32'(2'b10));
    check("rr_third", 32'(rr_seen[2]), 32'(2'b01));
    idle_in(); cycle();

    // Core read of 0x10, address changed mid-transfer, done 3 cycles after strobe.
    d_rd = 2'b01; d_addr[0] = 16'h0010; cycle();
    cycle();
    check("strobe_n1", 32'(obs_rs), 32'(1'b1));
    d_addr[0] = 16'h0020; cycle();
    check("addr_held", 32'(obs_addr), 32'(16'h0010));
    cycle();
    d_brd = 1'b1; d_bdin = 16'hBEEF; cycle();
    check("core_rdone", 32'(obs_rdone), 32'(2'b01));
    check("core_rdata", 32'(obs_din), 32'(16'hBEEF));
    check("core_grant", 32'(obs_grant), 32'(2'b01));
    idle_in(); cycle(); cycle();
    check("no_regrant", 32'(obs_grant), 32'(2'b00));

    // Bus never answers: exactly one timeout.
    d_rd = 2'b01; d_addr[0] = 16'h0030; cycle();
    idle_in(); terr_seen = 0;
    repeat (8) cycle();
    check("timeout_once", 32'(terr_seen), 32'(1));

    // write_done during a read is ignored; the later read_done completes it.
    d_rd = 2'b10; d_addr[1] = 16'h0040; cycle();
    idle_in(); d_bwd = 1'b1; cycle();
    check("wdone_ignored", 32'({obs_rdone, obs_wdone}), 32'(4'b0000));
    d_bwd = 1'b0; cycle();
    d_brd = 1'b1; d_bdin = 16'h5A5A; cycle();
    check("m1_rdone", 32'(obs_rdone), 32'(2'b10));
    idle_in(); cycle();

    // Read and write together from one requester becomes a write.
    d_rd = 2'b01; d_wr = 2'b01; d_dout[0] = 16'hA5A5; cycle();
    idle_in(); cycle();
    check("rw_is_write", 32'({obs_rs, obs_ws}), 32'(2'b01));
    d_bwd = 1'b1; cycle();
    check("rw_wdone", 32'(obs_wdone), 32'(2'b01));
    idle_in(); cycle();

    // Reset during a write aborts silently.
    d_wr = 2'b10; d_addr[1] = 16'h0050; cycle();
    idle_in(); cycle();
    d_rst = 1'b1; d_bwd = 1'b1; cycle();
    check("rst_no_done", 32'(obs_wdone), 32'(2'b00));
    idle_in(); cycle();
    check("rst_strobe_low", 32'({obs_rs, obs_ws}), 32'(2'b00));

    // Randomized traffic, including stray dones and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      d_rst = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < 2; k++) begin
        d_rd[k]   = ($urandom_range(0, 2) == 0);
        d_wr[k]   = ($urandom_range(0, 2) == 0);
        d_addr[k] = AW'($urandom);
        d_dout[k] = DW'($urandom);
      end
      d_brd  = ($urandom_range(0, 3) == 0);
      d_bwd  = ($urandom_range(0, 3) == 0);
      d_bdin = DW'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
